// File: rtl/risc_core.sv
// Multicycle 16-bit load/store core sharing one memory port for fetch and data.
// Define RISC_CORE_BRANCH_EN to decode opcode 001/op 00 as a conditional branch.
module risc_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_ready,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [2:0]        status,
  output logic              halted
);

  typedef enum logic [3:0] {
    S_RST, S_IF, S_DEC, S_GETA, S_GETB, S_EXEC,
    S_WB, S_ADDR, S_MRD, S_GETD, S_MWR, S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [DATA_W-1:0] data_reg;

  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [1:0]        sh_code;
  logic [2:0]        rm;
  logic [DATA_W-1:0] sximm8;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] rm_val;
  logic [DATA_W-1:0] rm_sh;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_out;
  logic              cmp_v;
  logic              is_movi, is_movr, is_alu, is_cmp, is_ldr, is_str, is_halt;

  assign opcode  = ir[15:13];
  assign op      = ir[12:11];
  assign rn      = ir[10:8];
  assign rd      = ir[7:5];
  assign sh_code = ir[4:3];
  assign rm      = ir[2:0];
  assign sximm8  = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign sximm5  = {{(DATA_W-5){ir[4]}}, ir[4:0]};

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
  assign is_str  = (opcode == 3'b100) && (op == 2'b00);
  assign is_halt = (opcode == 3'b111) && (op == 2'b00);

  always_comb begin
    rm_val = regs[rm];
    case (sh_code)
      2'b01:   rm_sh = rm_val << 1;
      2'b10:   rm_sh = rm_val >> 1;
      2'b11:   rm_sh = {rm_val[DATA_W-1], rm_val[DATA_W-1:1]};
      default: rm_sh = rm_val;
    endcase
  end

  always_comb begin
    diff    = a - b;
    cmp_v   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    alu_out = b;
    if (is_alu) begin
      case (op)
        2'b00:   alu_out = a + b;
        2'b10:   alu_out = a & b;
        2'b11:   alu_out = ~b;
        default: alu_out = diff;
      endcase
    end
  end

`ifdef RISC_CORE_BRANCH_EN
  logic is_branch;
  logic take_branch;

  // Condition codes live in the Rn field; status is {N,V,Z}.
  always_comb begin
    is_branch = (opcode == 3'b001) && (op == 2'b00);
    case (rn)
      3'b000:  take_branch = 1'b1;
      3'b001:  take_branch = status[0];
      3'b010:  take_branch = !status[0];
      3'b011:  take_branch = status[2] ^ status[1];
      3'b100:  take_branch = (status[2] ^ status[1]) | status[0];
      default: take_branch = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RST;
      pc       <= ADDR_W'(RESET_PC);
      ir       <= '0;
      status   <= '0;
      addr_reg <= '0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      data_reg <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_RST: state <= S_IF;
        S_IF: begin
          if (mem_ready) begin
            ir    <= read_data[15:0];
            pc    <= pc + ADDR_W'(1);
            state <= S_DEC;
          end
        end
        S_DEC: begin
          if (is_movi) state <= S_WB;
          else if (is_movr || is_alu || is_ldr || is_str) state <= S_GETA;
          else if (is_halt) state <= S_HALT;
`ifdef RISC_CORE_BRANCH_EN
          else if (is_branch && take_branch) begin
            pc    <= pc + ADDR_W'(sximm8);
            state <= S_IF;
          end
`endif
          else state <= S_IF;
        end
        // Operands are captured here so a write to a source register cannot disturb them.
        S_GETA: begin
          a     <= regs[rn];
          state <= (is_ldr || is_str) ? S_ADDR : S_GETB;
        end
        S_GETB: begin
          b     <= rm_sh;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_cmp) begin
            status <= {diff[DATA_W-1], cmp_v, (diff == '0)};
            state  <= S_IF;
          end else begin
            c     <= alu_out;
            state <= S_WB;
          end
        end
        S_WB: begin
          if (is_movi) regs[rn] <= sximm8;
          else regs[rd] <= c;
          state <= S_IF;
        end
        S_ADDR: begin
          addr_reg <= ADDR_W'(a + sximm5);
          state    <= is_ldr ? S_MRD : S_GETD;
        end
        S_MRD: begin
          if (mem_ready) begin
            regs[rd] <= read_data;
            state    <= S_IF;
          end
        end
        S_GETD: begin
          data_reg <= regs[rd];
          state    <= S_MWR;
        end
        S_MWR: if (mem_ready) state <= S_IF;
        S_HALT: state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  assign mem_cmd    = (state == S_IF || state == S_MRD) ? 2'b01 :
                      (state == S_MWR)                  ? 2'b10 : 2'b00;
  assign mem_addr   = (state == S_IF) ? pc : addr_reg;
  assign write_data = data_reg;
  assign halted     = (state == S_HALT);

endmodule

// File: doc/risc_core.md
RISC_CORE -- requirements
Module: risc_core

Interface
REQ-001 Parameter DATA_W, default 16: datapath/register width; SHALL be >=16, instruction in read_data[15:0].
REQ-002 Parameter ADDR_W, default 9: PC and memory address width.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 read_data  input  DATA_W  memory read data; valid when mem_ready=1 during a read.
REQ-007 mem_ready  input  1  memory completes the current read/write in this cycle.
REQ-008 mem_cmd  output  2  00 none, 01 read, 10 write; 11 never driven.
REQ-009 mem_addr  output  ADDR_W  memory address for the current mem_cmd.
REQ-010 write_data  output  DATA_W  store data; valid while mem_cmd=10.
REQ-011 status  output  3  {N,V,Z} flags, updated only by CMP.
REQ-012 halted  output  1  high while FSM is in HALT.

Function
REQ-013 Instruction fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0], imm5[4:0]; sximm8/sximm5 sign-extended to DATA_W; eight registers R0-R7.
REQ-014 Decode: 110/10 MOV Rn,#sximm8; 110/00 MOV Rd,sh(Rm); 101/00 ADD Rd=Rn+sh(Rm); 101/01 CMP Rn-sh(Rm); 101/10 AND Rd=Rn&sh(Rm); 101/11 MVN Rd=~sh(Rm); 011/00 LDR Rd,[Rn+sximm5]; 100/00 STR Rd,[Rn+sximm5]; 111/00 HALT; any other encoding is a NOP.
REQ-015 Shifter sh: 00 none, 01 LSL by 1, 10 LSR by 1 zero-fill, 11 ASR by 1; applies only to the Rm operand.
REQ-016 Arithmetic modulo 2^DATA_W; CMP sets Z=(result==0), N=result MSB, V=signed overflow of Rn-sh(Rm).
REQ-017 States: RST, IF, DEC, GETA, GETB, EXEC, WB, ADDR, MRD, GETD, MWR, HALT.
REQ-018 RST -> IF unconditionally one cycle after reset deasserts.
REQ-019 IF: mem_cmd=01, mem_addr=PC; hold until mem_ready; on mem_ready load IR from read_data[15:0], PC<=PC+1 wrapping modulo 2^ADDR_W, go DEC.
REQ-020 DEC: MOV-imm -> WB; MOV/ALU -> GETA; LDR/STR -> GETA; HALT -> HALT; NOP -> IF.
REQ-021 GETA -> GETB -> EXEC; EXEC: CMP updates status then -> IF, all other ALU/MOV -> WB; WB writes result to Rd (Rn for MOV-imm) then -> IF.
REQ-022 LDR/STR: GETA -> ADDR; ADDR latches (Rn+sximm5) truncated to ADDR_W into address register; LDR -> MRD, STR -> GETD -> MWR.
REQ-023 MRD: mem_cmd=01 at latched address until mem_ready; Rd<=read_data on that edge, then -> IF.
REQ-024 MWR: mem_cmd=10, write_data=Rd, address held until mem_ready, then -> IF.
REQ-025 Latency with mem_ready=1 every cycle: MOV-imm 3 cycles, CMP 5, other ALU/MOV 6, LDR 5, STR 6, IF-to-IF inclusive of fetch.
REQ-026 mem_ready=0 stalls IF/MRD/MWR indefinitely with mem_cmd, mem_addr, write_data stable; mem_ready ignored when mem_cmd=00.
REQ-027 HALT: mem_cmd=00, halted=1, registers and PC frozen; exit only by reset.
REQ-028 Writes to the same register read in the same instruction (e.g. ADD R1,R1,R1) SHALL use operand values captured in GETA/GETB.

Reset
REQ-029 reset=0 SHALL immediately force state RST, PC=RESET_PC, IR=0, status=000, R0-R7=0, mem_cmd=00, halted=0.
REQ-030 Reset asserted mid-handshake abandons the transfer; no register or memory write occurs for that instruction.

Configuration
REQ-031 Macro RISC_CORE_BRANCH_EN: when defined, opcode 001/op 00 is a conditional branch, cond in Rn field: 000 B, 001 BEQ(Z), 010 BNE(!Z), 011 BLT(N!=V), 100 BLE(N!=V or Z), others NOP.
REQ-032 Taken branch: in DEC, PC<=PC+sximm8 (PC already incremented) modulo 2^ADDR_W, -> IF; untaken -> IF; 2 cycles either way.
REQ-033 When RISC_CORE_BRANCH_EN is undefined, opcode 001 SHALL decode as NOP.

Verification
REQ-034 Reset then program MOV R0,#7; MOV R1,#-2; ADD R2,R0,R1; HALT with mem_ready=1 -> R2=5, halted=1, PC=4, fetches at addresses 0..3.
REQ-035 MOV R3,#0x40; STR R3,[R3,#1]; LDR R4,[R3,#1] -> write at addr 0x41 data 0x0040, R4=0x0040.
REQ-036 R0=0x8000, R1=1; CMP R0,R1 -> status N=0,V=1,Z=0; MVN R5,R1,LSL#1 -> R5=0xFFFD.
REQ-037 mem_ready held 0 for 4 cycles during IF and MWR -> mem_cmd/mem_addr/write_data stable throughout, instruction completes 4 cycles late.
REQ-038 PC=2^ADDR_W-1 with NOP -> next fetch at address 0; reset asserted during MWR stall -> mem_cmd=00 same cycle, target register/memory unchanged.
REQ-039 With RISC_CORE_BRANCH_EN: CMP R0,R0 then BEQ #-3 at addr 5 -> next fetch addr 3; without macro -> next fetch addr 6.
